// File: rtl/timer_ctrl_if.sv
// Key, switch and display-side signals of the countdown timer controller.
interface timer_ctrl_if;
  logic       set_key;
  logic       toggle_key;
  logic [7:0] sw_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       blank;
  logic [2:0] state_code;
  logic       done;

  modport master (
    output set_key, toggle_key, sw_bcd,
    input  sec_bcd, min_bcd, blank, state_code, done
  );

  modport slave (
    input  set_key, toggle_key, sw_bcd,
    output sec_bcd, min_bcd, blank, state_code, done
  );
endinterface

// File: rtl/timer_ctrl.sv
// Minute:second countdown sequencing controller with key synchronizers and 1 Hz prescaler.
// Optional key stability filter enabled by defining TIMER_DEBOUNCE_EN.
//
//   state      | meaning
//   SET_SEC  1 | waiting for set press to load seconds from switches
//   SET_MIN  2 | waiting for set press to load minutes from switches
//   STOPPED  3 | time held; toggle starts, set returns to SET_SEC
//   RUNNING  4 | counting down once per TICK_DIV cycles
//   FLASH    5 | reached 00:00; blank toggles every FLASH_DIV cycles
module timer_ctrl #(
  parameter int TICK_DIV        = 50000000,
  parameter int FLASH_DIV       = 12500000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);

  if (TICK_DIV < 2 || FLASH_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("timer_ctrl: TICK_DIV must be >= 2, FLASH_DIV and DEBOUNCE_CYCLES >= 1");
  end

  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_DIV + 1);
  localparam logic [TW-1:0] TICK_LOAD  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    S_SET_SEC = 3'd1,
    S_SET_MIN = 3'd2,
    S_STOPPED = 3'd3,
    S_RUNNING = 3'd4,
    S_FLASH   = 3'd5
  } state_t;

  state_t state, state_next;

  logic [1:0] key_raw;
  logic [1:0] sync1, sync2, filt, filt_prev;
  logic       press_set, press_tog;

  logic [7:0]    sec_q, min_q;
  logic          blank_q, done_q;
  logic [TW-1:0] pre_cnt;
  logic [FW-1:0] flash_cnt;

  logic          load_sec, load_min, do_dec;
  logic          tick, time_zero, dec_zero;
  logic [7:0]    sec_sw, min_sw, dec_sec, dec_min;

  // bit 0 = set key, bit 1 = toggle key
  assign key_raw = {bus.toggle_key, bus.set_key};

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      filt_prev <= 2'b11;
    end else begin
      sync1     <= key_raw;
      sync2     <= sync1;
      filt_prev <= filt;
    end
  end

`ifdef TIMER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LOAD = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt [2];
  logic [1:0]    filt_q;

  // filtered value follows the synced key only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      filt_q <= 2'b11;
      for (int k = 0; k < 2; k++) db_cnt[k] <= DB_LOAD;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == filt_q[k]) begin
          db_cnt[k] <= DB_LOAD;
        end else if (db_cnt[k] == '0) begin
          filt_q[k] <= sync2[k];
          db_cnt[k] <= DB_LOAD;
        end else begin
          db_cnt[k] <= db_cnt[k] - 1'b1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2;
`endif

  assign press_set = filt_prev[0] & ~filt[0];
  assign press_tog = filt_prev[1] & ~filt[1];

  assign sec_sw = (bus.sw_bcd[7:4] > 4'd5 || bus.sw_bcd[3:0] > 4'd9) ? 8'h59 : bus.sw_bcd;
  assign min_sw = (bus.sw_bcd[7:4] > 4'd9 || bus.sw_bcd[3:0] > 4'd9) ? 8'h99 : bus.sw_bcd;

  always_comb begin
    dec_sec = sec_q;
    dec_min = min_q;
    if (sec_q[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_q[3:0] - 4'd1;
    end else if (sec_q[7:4] != 4'd0) begin
      dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec = 8'h59;
      if (min_q[3:0] != 4'd0) begin
        dec_min[3:0] = min_q[3:0] - 4'd1;
      end else if (min_q[7:4] != 4'd0) begin
        dec_min = {min_q[7:4] - 4'd1, 4'd9};
      end
    end
  end

  assign time_zero = (sec_q == 8'h00) && (min_q == 8'h00);
  assign dec_zero  = (dec_sec == 8'h00) && (dec_min == 8'h00);
  assign tick      = (state == S_RUNNING) && (pre_cnt == '0);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) state <= S_SET_SEC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_sec   = 1'b0;
    load_min   = 1'b0;
    do_dec     = 1'b0;
    case (state)
      S_SET_SEC: begin
        if (press_set) begin
          load_sec   = 1'b1;
          state_next = S_SET_MIN;
        end
      end
      S_SET_MIN: begin
        if (press_set) begin
          load_min   = 1'b1;
          state_next = S_STOPPED;
        end
      end
      S_STOPPED: begin
        if (press_set)      state_next = S_SET_SEC;
        else if (press_tog) state_next = time_zero ? S_FLASH : S_RUNNING;
      end
      S_RUNNING: begin
        // the final tick wins over a coincident toggle press
        if (tick) begin
          do_dec = 1'b1;
          if (dec_zero)       state_next = S_FLASH;
          else if (press_tog) state_next = S_STOPPED;
        end else if (press_tog) begin
          state_next = S_STOPPED;
        end
      end
      S_FLASH: begin
        if (press_set) state_next = S_SET_SEC;
      end
      default: state_next = S_SET_SEC;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      blank_q   <= 1'b0;
      done_q    <= 1'b0;
      pre_cnt   <= TICK_LOAD;
      flash_cnt <= FLASH_LOAD;
    end else begin
      if (load_sec) sec_q <= sec_sw;
      if (load_min) min_q <= min_sw;
      if (do_dec) begin
        sec_q <= dec_sec;
        min_q <= dec_min;
      end

      // prescaler restarts whenever RUNNING is entered or left
      if (state == S_RUNNING && state_next == S_RUNNING)
        pre_cnt <= (pre_cnt == '0) ? TICK_LOAD : pre_cnt - 1'b1;
      else
        pre_cnt <= TICK_LOAD;

      if (state == S_FLASH && state_next == S_FLASH) begin
        if (flash_cnt == '0) begin
          blank_q   <= ~blank_q;
          flash_cnt <= FLASH_LOAD;
        end else begin
          flash_cnt <= flash_cnt - 1'b1;
        end
      end else begin
        blank_q   <= 1'b0;
        flash_cnt <= FLASH_LOAD;
      end

      done_q <= (state_next == S_FLASH) && (state != S_FLASH);
    end
  end

  assign bus.sec_bcd    = sec_q;
  assign bus.min_bcd    = min_q;
  assign bus.blank      = blank_q;
  assign bus.done       = done_q;
  assign bus.state_code = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with small dividers; covers both key-filter builds.
module tb_timer_ctrl;
  localparam int TICK_DIV  = 4;
  localparam int FLASH_DIV = 2;
  localparam int DB        = 3;
`ifdef TIMER_DEBOUNCE_EN
  localparam int LAT = DB + 3;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  timer_ctrl_if bus ();

  timer_ctrl #(
    .TICK_DIV        (TICK_DIV),
    .FLASH_DIV       (FLASH_DIV),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic keys_down(input logic s, input logic t);
    if (s) bus.set_key = 1'b0;
    if (t) bus.toggle_key = 1'b0;
    step(LAT);
  endtask

  task automatic keys_up();
    bus.set_key    = 1'b1;
    bus.toggle_key = 1'b1;
    step(LAT + 1);
  endtask

  task automatic press_set();
    keys_down(1'b1, 1'b0);
    keys_up();
  endtask

  task automatic load_time(input logic [7:0] s, input logic [7:0] m);
    bus.sw_bcd = s;
    press_set();
    bus.sw_bcd = m;
    press_set();
  endtask

  initial begin
    bus.set_key    = 1'b1;
    bus.toggle_key = 1'b1;
    bus.sw_bcd     = 8'h00;
    reset          = 1'b0;
    step(2);
    check_val("rst_state", bus.state_code, 3'd1);
    check_val("rst_sec",   bus.sec_bcd, 8'h00);
    check_val("rst_min",   bus.min_bcd, 8'h00);
    check_val("rst_blank", bus.blank, 1'b0);
    check_val("rst_done",  bus.done, 1'b0);
    reset = 1'b1;
    step(1);

    // basic load sequence
    bus.sw_bcd = 8'h45;
    press_set();
    check_val("ld_state2", bus.state_code, 3'd2);
    check_val("ld_sec45",  bus.sec_bcd, 8'h45);
    bus.sw_bcd = 8'h02;
    press_set();
    check_val("ld_state3", bus.state_code, 3'd3);
    check_val("ld_min02",  bus.min_bcd, 8'h02);
    check_val("ld_blank",  bus.blank, 1'b0);
    press_set();
    check_val("stop_set_state", bus.state_code, 3'd1);
    check_val("stop_set_keep",  bus.sec_bcd, 8'h45);

    // 00:01 run to FLASH, then blink timing
    load_time(8'h01, 8'h00);
    keys_down(1'b0, 1'b1);
    check_val("run_entry", bus.state_code, 3'd4);
    bus.toggle_key = 1'b1;
    step(3);
    check_val("run_pre_state", bus.state_code, 3'd4);
    check_val("run_pre_sec",   bus.sec_bcd, 8'h01);
    check_val("run_pre_done",  bus.done, 1'b0);
    step(1);
    check_val("fin_state", bus.state_code, 3'd5);
    check_val("fin_sec",   bus.sec_bcd, 8'h00);
    check_val("fin_min",   bus.min_bcd, 8'h00);
    check_val("fin_done",  bus.done, 1'b1);
    check_val("fin_blank", bus.blank, 1'b0);
    step(1);
    check_val("done_once",  bus.done, 1'b0);
    check_val("blank_e1",   bus.blank, 1'b0);
    step(1);
    check_val("blank_e2",   bus.blank, 1'b1);
    step(2);
    check_val("blank_e4",   bus.blank, 1'b0);
    step(2);
    check_val("blank_e6",   bus.blank, 1'b1);
    keys_down(1'b1, 1'b0);
    check_val("flash_exit_state", bus.state_code, 3'd1);
    check_val("flash_exit_blank", bus.blank, 1'b0);
    keys_up();

    // minute borrow: 01:00 -> 00:59, then stop holds time
    load_time(8'h00, 8'h01);
    keys_down(1'b0, 1'b1);
    bus.toggle_key = 1'b1;
    step(4);
    check_val("borrow_sec",   bus.sec_bcd, 8'h59);
    check_val("borrow_min",   bus.min_bcd, 8'h00);
    check_val("borrow_state", bus.state_code, 3'd4);
    keys_down(1'b0, 1'b1);
    check_val("pause_state", bus.state_code, 3'd3);
    check_val("pause_sec",   bus.sec_bcd, (LAT > 4) ? 8'h58 : 8'h59);
    keys_up();
    press_set();

    // tens borrow: 00:10 -> 00:09
    load_time(8'h10, 8'h00);
    keys_down(1'b0, 1'b1);
    bus.toggle_key = 1'b1;
    step(4);
    check_val("tens_sec", bus.sec_bcd, 8'h09);
    check_val("tens_min", bus.min_bcd, 8'h00);
    keys_down(1'b0, 1'b1);
    keys_up();
    press_set();
    check_val("back_set_sec", bus.state_code, 3'd1);

    // invalid switch values clamp
    bus.sw_bcd = 8'h7A;
    press_set();
    check_val("clamp_sec",   bus.sec_bcd, 8'h59);
    check_val("clamp_state", bus.state_code, 3'd2);
    bus.sw_bcd = 8'hA3;
    press_set();
    check_val("clamp_min",   bus.min_bcd, 8'h99);

    // simultaneous set+toggle in STOPPED: set wins
    keys_down(1'b1, 1'b1);
    check_val("both_state", bus.state_code, 3'd1);
    keys_up();

    // reset aborts a running count
    load_time(8'h05, 8'h00);
    keys_down(1'b0, 1'b1);
    bus.toggle_key = 1'b1;
    step(2);
    check_val("pre_rst_state", bus.state_code, 3'd4);
    reset = 1'b0;
    step(1);
    check_val("mid_rst_state", bus.state_code, 3'd1);
    check_val("mid_rst_sec",   bus.sec_bcd, 8'h00);
    check_val("mid_rst_min",   bus.min_bcd, 8'h00);
    check_val("mid_rst_blank", bus.blank, 1'b0);
    reset = 1'b1;
    step(1);

`ifndef TIMER_DEBOUNCE_EN
    // toggle press landing on the final tick still finishes into FLASH
    load_time(8'h01, 8'h00);
    keys_down(1'b0, 1'b1);
    bus.toggle_key = 1'b1;
    step(1);
    bus.toggle_key = 1'b0;
    step(3);
    check_val("coinc_state", bus.state_code, 3'd5);
    check_val("coinc_sec",   bus.sec_bcd, 8'h00);
    keys_up();
    press_set();
    check_val("coinc_exit", bus.state_code, 3'd1);
`endif

    // toggle at 00:00 goes straight to FLASH
    load_time(8'h00, 8'h00);
    keys_down(1'b0, 1'b1);
    check_val("zero_state", bus.state_code, 3'd5);
    check_val("zero_done",  bus.done, 1'b1);
    keys_up();
    press_set();
    check_val("zero_exit", bus.state_code, 3'd1);

`ifdef TIMER_DEBOUNCE_EN
    bus.set_key = 1'b0;
    step(2);
    bus.set_key = 1'b1;
    step(8);
    check_val("glitch_state", bus.state_code, 3'd1);
    bus.set_key = 1'b0;
    step(10);
    bus.set_key = 1'b1;
    step(10);
    check_val("long_press_state", bus.state_code, 3'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
